// File: rtl/freq_meter.sv
// freq_meter: counts synchronised rising edges of sig_in over a GATE_CYCLES window; define FREQ_METER_BCD_EN to add a BCD copy of the result
module freq_meter #(
    parameter int CLK_HZ      = 125000000,
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             overflow,
`ifdef FREQ_METER_BCD_EN
    output logic             busy,
    output logic [4*((CNT_W*30103)/100000+1)-1:0] bcd_out
`else
    output logic             busy
`endif
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    if (SYNC_STAGES < 2 || GATE_CYCLES < 1 || CLK_HZ < 1) begin : g_bad_params
        $error("freq_meter: SYNC_STAGES must be >= 2 and GATE_CYCLES/CLK_HZ positive");
    end

    typedef enum logic [2:0] {IDLE, ARM, GATE, LATCH, CONV} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   edge_q, edge_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   iovf_q, iovf_d, iovf_inc;
    logic [CNT_W-1:0]       freq_q, freq_d;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

`ifdef FREQ_METER_BCD_EN
    localparam int BCD_D = (CNT_W * 30103) / 100000 + 1;
    localparam int BW    = 4 * BCD_D;
    localparam int KW    = $clog2(CNT_W + 1);

    logic [CNT_W-1:0] bin_q, bin_d, bin_step;
    logic [BW-1:0]    acc_q, acc_d, acc_adj, acc_step;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [KW-1:0]    k_q, k_d, k_inc;

    // one double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < BCD_D; i++)
            acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
        acc_step = {acc_adj[BW-2:0], bin_q[CNT_W-1]};
        bin_step = bin_q << 1;
        k_inc    = k_q + 1'b1;
    end
`endif

    // synchroniser chain, history flop and registered rising-edge strobe
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        hist_d = sync_q[SYNC_STAGES-1];
        edge_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // edge counter holds at all-ones instead of wrapping and remembers that it did
    always_comb begin
        cnt_inc  = (edge_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        iovf_inc = iovf_q | (edge_q & (&cnt_q));
    end

    // measurement sequencer: arm, count for one gate window, latch the result
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        iovf_d  = iovf_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
`ifdef FREQ_METER_BCD_EN
        bin_d   = bin_q;
        acc_d   = acc_q;
        k_d     = k_q;
        bcd_d   = bcd_q;
`endif
        case (state_q)
            IDLE: state_d = enable ? ARM : IDLE;
            ARM: begin
                gate_d  = '0;
                cnt_d   = '0;
                iovf_d  = 1'b0;
                state_d = enable ? GATE : IDLE;
            end
            GATE: begin
                gate_d = gate_q + 1'b1;
                cnt_d  = cnt_inc;
                iovf_d = iovf_inc;
                if (!enable)
                    state_d = IDLE;
                else if (gate_q == GW'(GATE_CYCLES - 1)) begin
                    state_d = LATCH;
                    freq_d  = cnt_inc;
                    ovf_d   = iovf_inc;
`ifdef FREQ_METER_BCD_EN
                    bin_d   = cnt_inc;
                    acc_d   = '0;
                    k_d     = '0;
`else
                    valid_d = 1'b1;
`endif
                end
            end
`ifdef FREQ_METER_BCD_EN
            LATCH, CONV: begin
                if (state_q == CONV && k_q == KW'(CNT_W))
                    state_d = enable ? ARM : IDLE;
                else begin
                    state_d = CONV;
                    bin_d   = bin_step;
                    acc_d   = acc_step;
                    k_d     = k_inc;
                    if (k_inc == KW'(CNT_W)) begin
                        bcd_d   = acc_step;
                        valid_d = 1'b1;
                    end
                end
            end
`else
            LATCH: state_d = enable ? ARM : IDLE;
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ARM) || (state_d == GATE) || (state_d == CONV);
    end

    // all state and registered outputs; reset discards any partial measurement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            hist_q  <= 1'b0;
            edge_q  <= 1'b0;
            gate_q  <= '0;
            cnt_q   <= '0;
            iovf_q  <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FREQ_METER_BCD_EN
            bin_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            bcd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            edge_q  <= edge_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            iovf_q  <= iovf_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef FREQ_METER_BCD_EN
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            bcd_q   <= bcd_d;
`endif
        end
    end

    assign freq_out = freq_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
`ifdef FREQ_METER_BCD_EN
    assign bcd_out  = bcd_q;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances (12-bit and 5-bit counters) checked against a time-based model
module tb_freq_meter;
    localparam int G  = 1000;
    localparam int W1 = 12;
    localparam int W2 = 5;
`ifdef FREQ_METER_BCD_EN
    localparam int X1  = W1;
    localparam int X2  = W2;
    localparam int BW1 = 4 * ((W1 * 30103) / 100000 + 1);
    localparam int BW2 = 4 * ((W2 * 30103) / 100000 + 1);
`else
    localparam int X1 = 0;
    localparam int X2 = 0;
`endif

    logic clk = 0, rst_n = 0, sig_in = 0, enable = 0;
    logic [W1-1:0] freq1;
    logic [W2-1:0] freq2;
    logic valid1, valid2, ovf1, ovf2, busy1, busy2;
`ifdef FREQ_METER_BCD_EN
    logic [BW1-1:0] bcd1;
    logic [BW2-1:0] bcd2;
`endif

    int total = 0, bad = 0;
    int per = 10, hi = 5, ph = 0;

    bit          act[2], ev[2], eb[2], eovf[2];
    int          t[2], ecnt[2], efreq[2];
    logic [63:0] ebcd[2];

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freq1), .valid(valid1), .overflow(ovf1),
`ifdef FREQ_METER_BCD_EN
        .busy(busy1), .bcd_out(bcd1)
`else
        .busy(busy1)
`endif
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freq2), .valid(valid2), .overflow(ovf2),
`ifdef FREQ_METER_BCD_EN
        .busy(busy2), .bcd_out(bcd2)
`else
        .busy(busy2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic int wave_cnt();
        return (hi == 0 || hi >= per) ? 0 : G / per;
    endfunction

    function automatic int maxv(input int d);
        return d == 0 ? (1 << W1) - 1 : (1 << W2) - 1;
    endfunction

    function automatic int endt(input int d);
        return G + 1 + (d == 0 ? X1 : X2);
    endfunction

    function automatic logic [63:0] to_bcd(input int v);
        logic [63:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // square wave generator: period per cycles, high for the first hi cycles
    initial forever begin
        @(negedge clk);
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        sig_in = (ph < hi);
    end

    // model: a measurement starts when enabled, gates G cycles, and reports G/per edges
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                act[d] = 0; t[d] = 0; efreq[d] = 0; eovf[d] = 0; ebcd[d] = '0;
            end else if (!act[d]) begin
                if (enable) begin act[d] = 1; t[d] = 0; ecnt[d] = wave_cnt(); end
            end else if (t[d] <= G) begin
                if (enable) t[d]++; else act[d] = 0;
            end else if (t[d] < endt(d)) begin
                t[d]++;
            end else if (enable) begin
                t[d] = 0; ecnt[d] = wave_cnt();
            end else begin
                act[d] = 0;
            end
            ev[d] = rst_n && act[d] && t[d] == endt(d);
            eb[d] = rst_n && act[d] && (t[d] <= G || t[d] > G + 1);
            if (ev[d]) begin
                efreq[d] = ecnt[d] > maxv(d) ? maxv(d) : ecnt[d];
                eovf[d]  = ecnt[d] > maxv(d);
                ebcd[d]  = to_bcd(efreq[d]);
            end
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("valid1", valid1, ev[0]);
        chk("busy1", busy1, eb[0]);
        chk("freq1", freq1, efreq[0]);
        chk("ovf1", ovf1, eovf[0]);
        chk("valid2", valid2, ev[1]);
        chk("busy2", busy2, eb[1]);
        chk("freq2", freq2, efreq[1]);
        chk("ovf2", ovf2, eovf[1]);
`ifdef FREQ_METER_BCD_EN
        chk("bcd1", bcd1, ebcd[0][BW1-1:0]);
        chk("bcd2", bcd2, ebcd[1][BW2-1:0]);
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!valid1 && n < 5000);
        if (!valid1) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: no valid within %0d cycles", n);
        end
    endtask

    task automatic set_wave(input int p, input int h);
        per = p;
        hi  = h;
    endtask

    task automatic release_rst;
        int g = 0;
        do begin
            step(1);
            g++;
        end while (!(ph == hi && sig_in == 1'b0) && g < 2000);
        rst_n = 1;
    endtask

    initial begin
        int n;
        int plist[8] = '{4, 5, 8, 10, 20, 25, 40, 50};
        set_wave(10, 5);
        enable = 1;
        step(5);
        chk("rst_freq", freq1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ovf", ovf1, 0);
        release_rst;
        wait_valid(n);
        chk("first_latency", n, 1002 + X1);
        chk("p10_freq", freq1, 100);
        chk("p10_ovf", ovf1, 0);
        chk("p10_sat_freq5", freq2, 31);
        chk("p10_sat_ovf5", ovf2, 1);
        wait_valid(n);
        chk("period", n, 1002 + X1);

        step(502);
        enable = 0;
        step(1);
        chk("abort_busy", busy1, 0);
        step(1500);
        chk("abort_hold", freq1, 100);
        enable = 1;
        wait_valid(n);
        chk("reenable_latency", n, 1002 + X1);
        chk("reenable_freq", freq1, 100);

        enable = 0; step(30); set_wave(10, 0); step(20); enable = 1;
        wait_valid(n);
        chk("const0_freq", freq1, 0);
        enable = 0; step(30); set_wave(10, 10); step(20); enable = 1;
        wait_valid(n);
        chk("const1_freq", freq1, 0);
        chk("const1_freq5", freq2, 0);

        enable = 0; step(30); set_wave(4, 2); step(20); enable = 1;
        wait_valid(n);
        chk("p4_freq", freq1, 250);
        chk("p4_sat_freq5", freq2, 31);
        chk("p4_sat_ovf5", ovf2, 1);
        enable = 0; step(30); set_wave(100, 50); step(20); enable = 1;
        wait_valid(n);
        chk("p100_freq5", freq2, 10);
        chk("p100_ovf5", ovf2, 0);

        enable = 0; step(30); set_wave(8, 4); step(20); enable = 1;
        wait_valid(n);
        chk("p8_freq", freq1, 125);
`ifdef FREQ_METER_BCD_EN
        chk("p8_bcd", bcd1, 16'h0125);
`endif

        enable = 0; step(30); set_wave(10, 5); step(20); enable = 1;
        step(500);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_freq", freq1, 0);
        chk("midrst_freq5", freq2, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_valid", valid1, 0);
        step(3);
        release_rst;
        wait_valid(n);
        chk("postrst_latency", n, 1002 + X1);
        chk("postrst_freq", freq1, 100);

        for (int i = 0; i < 16; i++) begin
            int p;
            enable = 0;
            step(30);
            p = plist[$urandom_range(7, 0)];
            set_wave(p, int'($urandom_range(p - 2, 2)));
            step(20);
            enable = 1;
            step(int'($urandom_range(2600, 200)));
        end
        enable = 0;
        step(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
